// File: rtl/i2c_target_pkg.sv
// I2C target: shared FSM state encoding and bus-condition event type.
// Latency: none (types only). Backpressure: none (types only).
// Used by the edge synchronizer and by the register-file target.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } state_e;

  typedef struct packed {
    logic start;
    logic stop;
  } bus_evt_t;

endpackage

// File: rtl/i2c_edge_sync.sv
// SCL/SDA synchronizers with SCL edge and START/STOP detectors.
// Latency: SYNC_STAGES+1 clocks from pin to event. Backpressure: none; events are single-cycle pulses.
// Synchronizers reset to 1 so that an idle bus produces no spurious events.
module i2c_edge_sync
  import i2c_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  logic     scl_i,
  input  logic     sda_i,
  output logic     sda_o,
  output logic     scl_rise_o,
  output logic     scl_fall_o,
  output bus_evt_t evt_o
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_s;
  logic                   sda_s;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_prev <= scl_s;
      sda_prev <= sda_s;
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign sda_o       = sda_s;
  assign scl_rise_o  = scl_s & ~scl_prev;
  assign scl_fall_o  = ~scl_s & scl_prev;
  // SDA may only change while SCL is high for a bus condition.
  assign evt_o.start = scl_s & scl_prev & sda_prev & ~sda_s;
  assign evt_o.stop  = scl_s & scl_prev & ~sda_prev & sda_s;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with 256x8 register file, pointer register and auto-increment.
// Latency: write pulse on the 8th SCL rise (+sync delay); dbg read 1 clock. Backpressure: none, never stretches SCL.
// Every data byte written is reported once on wr_valid_o with its pre-increment address.
module i2c_target_regfile
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h39,
  parameter int         NREGS       = 256,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       wr_valid_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  input  logic [7:0] dbg_addr_i,
  output logic [7:0] dbg_data_o,
  output logic       busy_o
);

  localparam int AW = $clog2(NREGS);

  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  bus_evt_t   evt;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic       wr_valid_q, wr_valid_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       reg_we;
  logic [7:0] byte_in;
  logic [7:0] rd_byte;

  logic [7:0] regs [NREGS];

  i2c_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .evt_o      (evt)
  );

  assign byte_in = {shreg_q[6:0], sda_s};
  assign rd_byte = regs[ptr_q];

  // In the ACK states bit_cnt is a phase counter rather than a bit count.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    reg_we     = 1'b0;

    if (evt.start) begin
      state_d   = DEV;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (evt.stop) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        DEV, PTR, WDATA: begin
          if (scl_rise) begin
            shreg_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              case (state_q)
                DEV: begin
                  if (byte_in[7:1] == DEV_ADDR) begin
                    state_d = DEV_ACK;
                    busy_d  = 1'b1;
                    rw_d    = byte_in[0];
                  end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                  end
                end
                PTR: begin
                  ptr_d   = byte_in[AW-1:0];
                  state_d = PTR_ACK;
                end
                default: begin
                  reg_we     = 1'b1;
                  wr_valid_d = 1'b1;
                  wr_addr_d  = 8'(ptr_q);
                  wr_data_d  = byte_in;
                  ptr_d      = ptr_q + AW'(1);
                  state_d    = WDATA_ACK;
                end
              endcase
            end
          end
        end
        DEV_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_oe_d  = 1'b1;
              bit_cnt_d = 3'd1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              case (state_q)
                DEV_ACK: begin
                  if (rw_q) begin
                    state_d  = RDATA;
                    sda_oe_d = ~rd_byte[7];
                    shreg_d  = {rd_byte[6:0], 1'b0};
                  end else begin
                    state_d = PTR;
                  end
                end
                default: state_d = WDATA;
              endcase
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              ptr_d     = ptr_q + AW'(1);
              state_d   = RDATA_ACK;
            end
          end else if (scl_fall) begin
            sda_oe_d = ~shreg_q[7];
            shreg_d  = {shreg_q[6:0], 1'b0};
          end
        end
        RDATA_ACK: begin
          // Phases: release SDA, sample master ACK/NACK, then drive next MSB.
          if (bit_cnt_q == 3'd0 && scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd1;
          end else if (bit_cnt_q == 3'd1 && scl_rise) begin
            if (sda_s) begin
              state_d   = IDLE;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = 3'd2;
            end
          end else if (bit_cnt_q == 3'd2 && scl_fall) begin
            state_d   = RDATA;
            bit_cnt_d = '0;
            sda_oe_d  = ~rd_byte[7];
            shreg_d   = {rd_byte[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Same-cycle dbg read of a written address returns the old contents.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      dbg_data_o <= '0;
    end else begin
      if (reg_we) regs[ptr_q] <= byte_in;
      dbg_data_o <= regs[dbg_addr_i[AW-1:0]];
    end
  end

  assign sda_oe_o   = sda_oe_q;
  assign busy_o     = busy_q;
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;

endmodule
